// File: rtl/fp32_result_buffer.sv
// Elastic FIFO for FP32 multiplier results with first-word fall-through and sticky status flags.
// Optional 8-bit saturating error counter when FP32_RESULT_ERRCNT_EN is defined.
module fp32_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  // Upstream (multiplier) side
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_res,
  input  logic          in_exception,
  input  logic          in_overflow,
  input  logic          in_underflow,
  // Downstream side
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_res,
  output logic          out_exception,
  output logic          out_overflow,
  output logic          out_underflow,
  // Status
  output logic [CW-1:0] count,
  output logic          sticky_exc,
  output logic          sticky_ovf,
  output logic          sticky_unf,
`ifdef FP32_RESULT_ERRCNT_EN
  output logic [7:0]    err_count,
`endif
  input  logic          clear_sticky
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic        ovf;
    logic        unf;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          in_entry;
  entry_t          head;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            sticky_exc_q, sticky_exc_d;
  logic            sticky_ovf_q, sticky_ovf_d;
  logic            sticky_unf_q, sticky_unf_d;
  logic            push, pop;

  assign in_entry = '{res: in_res, exc: in_exception, ovf: in_overflow, unf: in_underflow};

  // Handshake flags depend on registered occupancy only.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head          = mem_q[rd_ptr_q];
  assign out_res       = head.res;
  assign out_exception = head.exc;
  assign out_overflow  = head.ovf;
  assign out_underflow = head.unf;

  assign count      = count_q;
  assign sticky_exc = sticky_exc_q;
  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are PW bits wide, so increments wrap modulo DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A flagged push in the same cycle as clear_sticky leaves the flag set.
  always_comb begin
    sticky_exc_d = (sticky_exc_q & ~clear_sticky) | (push & in_exception);
    sticky_ovf_d = (sticky_ovf_q & ~clear_sticky) | (push & in_overflow);
    sticky_unf_d = (sticky_unf_q & ~clear_sticky) | (push & in_underflow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sticky_exc_q <= 1'b0;
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sticky_exc_q <= sticky_exc_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
      if (push) mem_q[wr_ptr_q] <= in_entry;
    end
  end

`ifdef FP32_RESULT_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  logic       flagged_push;

  assign flagged_push = push & (in_exception | in_overflow | in_underflow);
  assign err_count    = err_count_q;

  // Clear and increment together restart the count at one.
  always_comb begin
    err_count_d = err_count_q;
    if (clear_sticky) begin
      err_count_d = flagged_push ? 8'd1 : 8'd0;
    end else if (flagged_push && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end
`endif

endmodule

// File: doc/fp32_result_buffer.md
FP32_RESULT_BUFFER -- requirements
Module: fp32_result_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of entries; power of two, 2..16.
REQ-002 Parameter: CW, $clog2(DEPTH)+1, width of occupancy count.
REQ-003 Port: clk  input  1  rising-edge clock; sole clock.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  upstream FP32 multiplier result valid.
REQ-006 Port: in_ready  output  1  buffer can accept this cycle.
REQ-007 Port: in_res  input  32  FP32 product from multiplier.
REQ-008 Port: in_exception, in_overflow, in_underflow  input  1 each  multiplier status flags.
REQ-009 Port: out_valid  output  1  head entry available.
REQ-010 Port: out_ready  input  1  downstream consumes head.
REQ-011 Port: out_res  output  32  head product.
REQ-012 Port: out_exception, out_overflow, out_underflow  output  1 each  head flags.
REQ-013 Port: count  output  CW  current occupancy.
REQ-014 Port: sticky_exc, sticky_ovf, sticky_unf  output  1 each  accumulated status.
REQ-015 Port: clear_sticky  input  1  clears sticky flags.

Function
REQ-016 Entry = {res, exception, overflow, underflow}, 35 bits, stored as received; no modification of product or flags.
REQ-017 in_ready SHALL equal (count != DEPTH), combinationally from registered state only.
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_* SHALL present head entry whenever out_valid = 1 (first-word fall-through).
REQ-020 Latency: entry pushed at edge N visible on out_* with out_valid = 1 after edge N; no same-cycle input-to-output bypass.
REQ-021 Simultaneous push and pop (count neither 0 nor DEPTH) SHALL leave count unchanged and preserve order.
REQ-022 Full: in_valid ignored, no overwrite; pop while full SHALL raise in_ready next cycle.
REQ-023 Empty: out_ready ignored, count stays 0, no underflow of pointers.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; order preserved across wrap.
REQ-025 out_* values SHALL be don't-care when out_valid = 0 but SHALL NOT be X after reset.
REQ-026 Sticky flags SHALL set on accepted push carrying the matching flag; held until clear_sticky or rst.
REQ-027 clear_sticky with a same-cycle flagged push SHALL result in the flag set (set wins).

Reset
REQ-028 On rst: count = 0, pointers = 0, out_valid = 0, in_ready = 1, sticky_* = 0, storage cleared to 0.
REQ-029 rst SHALL override any push/pop/clear in the same cycle; entries in flight are discarded.
REQ-030 Reset mid-operation SHALL return to empty state after one edge; no partial entries.

Configuration
REQ-031 Macro FP32_RESULT_ERRCNT_EN: when defined, adds output err_count (8 bits) incrementing on each accepted push with in_exception|in_overflow|in_underflow, saturating at 255, cleared by rst or clear_sticky (increment wins over clear same cycle, giving 1).
REQ-032 Without FP32_RESULT_ERRCNT_EN: err_count port and logic absent; all other behaviour identical.

Verification
REQ-033 Reset then push 0x453210E9 flags 000, out_ready = 0 -> next cycle out_valid = 1, out_res = 0x453210E9, count = 1.
REQ-034 Push 0xC2355062, 0x441E5375, 0x4B800000, 0x00000000 with out_ready = 0 -> count = 4, in_ready = 0; 5th push 0x361FFFE7 refused; drain yields the four in order.
REQ-035 Full, simultaneous in_valid and out_ready -> pop only, count = 3, in_ready = 1 next cycle; then push/pop every cycle for 10 cycles across pointer wrap -> count constant, order intact.
REQ-036 Push 0x00000000 with exception = 1, overflow = 1 -> sticky_exc = sticky_ovf = 1, sticky_unf = 0; clear_sticky alone -> all 0; clear_sticky with flagged push -> flag 1.
REQ-037 rst asserted with count = 3 and in_valid = 1 -> next cycle count = 0, out_valid = 0, sticky_* = 0.
REQ-038 With FP32_RESULT_ERRCNT_EN: 300 flagged pushes with continuous drain -> err_count = 255; clear_sticky -> 0.
